// File: rtl/hazard_ctrl.sv
// Hazard, stall, flush and forwarding control for the 5-stage pipeline,
// including the busy tracker for the multi-cycle multiply/divide unit.
module hazard_ctrl #(
    parameter int MD_LATENCY  = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             rsD,
    input  logic [4:0]             rtD,
    input  logic [4:0]             rsE,
    input  logic [4:0]             rtE,
    input  logic [4:0]             writeRegE,
    input  logic [4:0]             writeRegM,
    input  logic [4:0]             writeRegW,
    input  logic                   regWriteE,
    input  logic                   regWriteM,
    input  logic                   regWriteW,
    input  logic                   memToRegE,
    input  logic                   memToRegM,
    input  logic                   branchD,
    input  logic                   pcSrcD,
    input  logic                   jumpD,
    input  logic                   mdUseD,
    input  logic                   mdStartE,
    output logic                   enF,
    output logic                   enD,
    output logic                   flushD,
    output logic                   flushE,
    output logic                   forwardAD,
    output logic                   forwardBD,
    output logic [1:0]             forwardAE,
    output logic [1:0]             forwardBE,
    output logic                   mdBusy,
    output logic                   mdDone,
    output logic                   mdOverlapErr,
    output logic [STALL_CNT_W-1:0] stallCount
);

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam logic [7:0]             MD_RELOAD = 8'(MD_LATENCY - 1);
    localparam logic [STALL_CNT_W-1:0] CNT_MAX   = {STALL_CNT_W{1'b1}};
    localparam logic [STALL_CNT_W-1:0] CNT_ONE   = STALL_CNT_W'(1);

    md_state_t              state_r;
    md_state_t              state_s;
    logic [7:0]             cnt_r;
    logic [7:0]             cnt_s;
    logic                   err_r;
    logic                   err_set_s;
    logic [STALL_CNT_W-1:0] stall_cnt_r;
    logic                   lw_stall_s;
    logic                   br_stall_s;
    logic                   md_stall_s;
    logic                   md_done_s;
    logic                   stall_s;

    // Register 0 is hardwired to zero and never creates a dependency.
    function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    // Hazard detection terms.
    always_comb begin
        md_done_s  = (state_r == MD_BUSY) && (cnt_r == 8'd0);
        lw_stall_s = memToRegE && regWriteE &&
                     (reg_match(writeRegE, rsD) || reg_match(writeRegE, rtD));
        br_stall_s = branchD &&
                     ((regWriteE && (reg_match(writeRegE, rsD) || reg_match(writeRegE, rtD))) ||
                      (memToRegM && (reg_match(writeRegM, rsD) || reg_match(writeRegM, rtD))));
        md_stall_s = mdUseD && (state_r == MD_BUSY) && !md_done_s;
        stall_s    = lw_stall_s || br_stall_s || md_stall_s;
    end

    // Pipeline enables, flushes and forwarding selects; reset holds the pipe frozen and flushed.
    always_comb begin
        enF       = 1'b0;
        enD       = 1'b0;
        flushD    = 1'b1;
        flushE    = 1'b1;
        forwardAD = 1'b0;
        forwardBD = 1'b0;
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        mdBusy    = 1'b0;
        mdDone    = 1'b0;
        if (rst) begin
            enF    = 1'b0;
            flushD = 1'b1;
        end else begin
            enF       = !stall_s;
            enD       = !stall_s;
            flushE    = stall_s;
            flushD    = (pcSrcD || jumpD) && !stall_s;
            forwardAD = regWriteM && reg_match(writeRegM, rsD);
            forwardBD = regWriteM && reg_match(writeRegM, rtD);
            mdBusy    = (state_r == MD_BUSY);
            mdDone    = md_done_s;
            if (regWriteM && reg_match(writeRegM, rsE)) begin
                forwardAE = 2'b10;
            end else if (regWriteW && reg_match(writeRegW, rsE)) begin
                forwardAE = 2'b01;
            end else begin
                forwardAE = 2'b00;
            end
            if (regWriteM && reg_match(writeRegM, rtE)) begin
                forwardBE = 2'b10;
            end else if (regWriteW && reg_match(writeRegW, rtE)) begin
                forwardBE = 2'b01;
            end else begin
                forwardBE = 2'b00;
            end
        end
    end

    // Mult/div next state; a start in the final busy cycle is a legal back-to-back issue.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        err_set_s = 1'b0;
        case (state_r)
            MD_IDLE: begin
                if (mdStartE) begin
                    state_s = MD_BUSY;
                    cnt_s   = MD_RELOAD;
                end else begin
                    state_s = MD_IDLE;
                end
            end
            MD_BUSY: begin
                if (cnt_r != 8'd0) begin
                    cnt_s     = cnt_r - 8'd1;
                    err_set_s = mdStartE;
                end else if (mdStartE) begin
                    state_s = MD_BUSY;
                    cnt_s   = MD_RELOAD;
                end else begin
                    state_s = MD_IDLE;
                end
            end
            default: begin
                state_s = MD_IDLE;
                cnt_s   = 8'd0;
            end
        endcase
    end

    // FSM, sticky overlap flag and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= MD_IDLE;
            cnt_r       <= 8'd0;
            err_r       <= 1'b0;
            stall_cnt_r <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            err_r   <= err_r || err_set_s;
            if (stall_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign mdOverlapErr = err_r;
    assign stallCount   = stall_cnt_r;

endmodule
